// File: rtl/mem_stage_mc.sv
// EX/MEM pipeline register and memory stage with variable-latency load return.
// Drives the WB bus and the ID forwarding bus from the registered instruction.
module mem_stage_mc #(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int RA_W      = 5,
    parameter int STALL_W   = 6,
    parameter int STALL_IDX = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic [PC_W-1:0]     ex_pc,
    input  logic                ex_mem_en,
    input  logic [DATA_W/8-1:0] ex_mem_wen,
    input  logic [2:0]          ex_ld_type,
    input  logic                ex_rf_we,
    input  logic [RA_W-1:0]     ex_rf_waddr,
    input  logic [DATA_W-1:0]   ex_result,
    input  logic [DATA_W-1:0]   data_rdata,
    input  logic                data_rvalid,
    output logic                stallreq,
    output logic                addr_err,
    output logic [PC_W-1:0]     wb_pc,
    output logic                wb_rf_we,
    output logic [RA_W-1:0]     wb_rf_waddr,
    output logic [DATA_W-1:0]   wb_rf_wdata,
    output logic                fwd_rf_we,
    output logic [RA_W-1:0]     fwd_rf_waddr,
    output logic [DATA_W-1:0]   fwd_rf_wdata,
    output logic                fwd_pending
);
    localparam int OFF_W = $clog2(DATA_W / 8);

    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_BU = 3'b010;
    localparam logic [2:0] LD_H  = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;
    localparam logic [2:0] LD_W  = 3'b101;
    localparam logic [2:0] LD_WU = 3'b110;

    typedef enum logic [1:0] {IDLE, WAIT, HAVE} state_t;

    state_t              state, state_nxt;
    logic [PC_W-1:0]     r_pc;
    logic                r_mem_en;
    logic [DATA_W/8-1:0] r_mem_wen;
    logic [2:0]          r_ld_type;
    logic                r_rf_we;
    logic [RA_W-1:0]     r_rf_waddr;
    logic [DATA_W-1:0]   r_result;
    logic [DATA_W-1:0]   rdata_buf;
    logic                buf_cap;

    logic hold_me, bubble, advance, is_load, mis;
    logic unused_stall;

    assign hold_me      = stall[STALL_IDX];
    assign bubble       = hold_me & ~stall[STALL_IDX+1];
    assign advance      = flush | bubble | ~hold_me;
    assign unused_stall = ^stall;

    always_ff @(posedge clk) begin
        if (rst | flush | bubble) begin
            r_pc       <= '0;
            r_mem_en   <= 1'b0;
            r_mem_wen  <= '0;
            r_ld_type  <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_result   <= '0;
        end else if (!hold_me) begin
            r_pc       <= ex_pc;
            r_mem_en   <= ex_mem_en;
            r_mem_wen  <= ex_mem_wen;
            r_ld_type  <= ex_ld_type;
            r_rf_we    <= ex_rf_we;
            r_rf_waddr <= ex_rf_waddr;
            r_result   <= ex_result;
        end
    end

    assign is_load = r_mem_en & ~|r_mem_wen;

    // Sub-word extraction from the current read data or the buffered copy
    logic [DATA_W-1:0] raw, ld_val, ext_w, ext_wu;
    logic [OFF_W-1:0]  off;
    logic [7:0]        sel_b;
    logic [15:0]       sel_h;

    assign raw   = data_rvalid ? data_rdata : rdata_buf;
    assign off   = r_result[OFF_W-1:0];
    assign sel_b = 8'(raw >> {off, 3'd0});
    assign sel_h = 16'(raw >> {off[OFF_W-1:1], 4'd0});

    if (DATA_W == 64) begin : g_w64
        logic [31:0] sel_w;
        assign sel_w  = 32'(raw >> {off[OFF_W-1], 5'd0});
        assign ext_w  = {{(DATA_W-32){sel_w[31]}}, sel_w};
        assign ext_wu = {{(DATA_W-32){1'b0}}, sel_w};
    end else begin : g_w32
        assign ext_w  = raw;
        assign ext_wu = raw;
    end

    always_comb begin
        ld_val = raw;
        mis    = 1'b0;
        unique case (r_ld_type)
            LD_B:  ld_val = {{(DATA_W-8){sel_b[7]}}, sel_b};
            LD_BU: ld_val = {{(DATA_W-8){1'b0}}, sel_b};
            LD_H: begin
                ld_val = {{(DATA_W-16){sel_h[15]}}, sel_h};
                mis    = off[0];
            end
            LD_HU: begin
                ld_val = {{(DATA_W-16){1'b0}}, sel_h};
                mis    = off[0];
            end
            LD_W: begin
                ld_val = ext_w;
                mis    = |off[1:0];
            end
            LD_WU: begin
                ld_val = ext_wu;
                mis    = |off[1:0];
            end
            default: begin
                ld_val = raw;
                mis    = |off;
            end
        endcase
    end

    assign addr_err = is_load & mis;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A register change abandons any outstanding load
    always_comb begin
        state_nxt = state;
        if (advance) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (is_load & ~addr_err)
                          state_nxt = data_rvalid ? HAVE : WAIT;
                WAIT: if (data_rvalid) state_nxt = HAVE;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        stallreq    = is_load & ~addr_err & (state != HAVE) & ~data_rvalid;
        fwd_pending = is_load & fwd_rf_we & (state != HAVE) & ~data_rvalid;
        buf_cap     = ~advance & data_rvalid &
                      ((state == WAIT) |
                       ((state == IDLE) & is_load & ~addr_err));
    end

    always_ff @(posedge clk) begin
        if (rst)          rdata_buf <= '0;
        else if (buf_cap) rdata_buf <= data_rdata;
    end

    assign wb_pc        = r_pc;
    assign wb_rf_we     = r_rf_we & ~addr_err;
    assign wb_rf_waddr  = r_rf_waddr;
    assign wb_rf_wdata  = is_load ? ld_val : r_result;
    assign fwd_rf_we    = wb_rf_we;
    assign fwd_rf_waddr = wb_rf_waddr;
    assign fwd_rf_wdata = wb_rf_wdata;
endmodule
